// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display controller:
// FSM state encoding and the active-low seven-segment lookup (bit k = segment a..g).
package hex_display_pkg;

    typedef enum logic [0:0] {
        LIVE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton conditioning: two-flop synchroniser, counting
// debouncer and a one-cycle press pulse on each debounced 1->0 transition.
// Presses are ignored until the key has been seen released for long enough
// after reset, so a key held through reset must be released and pressed again.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_keyN,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_levelD;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_armCnt;

    // Bring the asynchronous key into the clock domain; reset to released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_keyN;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Arm press detection once the key has read released for the full synchroniser
    // depth plus DEBOUNCE_CYCLES samples; the two reset-valued samples alone never arm it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed  <= 1'b0;
            r_armCnt <= '0;
        end else if (!r_armed) begin
            if (!r_sync2) begin
                r_armCnt <= '0;
            end else if (r_armCnt == ARM_LAST) begin
                r_armed <= 1'b1;
            end else begin
                r_armCnt <= r_armCnt + 1'b1;
            end
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_levelD <= 1'b1;
        end else begin
            r_levelD <= r_level;
        end
    end

    assign o_press = r_armed & r_levelD & ~r_level;

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display controller: shows DATA_IN live on NUM_DIGITS seven-segment digits,
// a debounced load key toggles a frozen HOLD view, a clear key zeroes the display.
// Optional feature macro: HEX_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic                    KEY_LOAD_N,
    input  logic                    KEY_CLR_N,
    output logic [7*NUM_DIGITS-1:0] HEX_OUT,
    output logic                    HOLD_LED,
    output logic [7:0]              PRESS_CNT
);

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [7:0]              r_pressCnt;
    logic                    w_loadPress;
    logic                    w_clrPress;
    logic                    w_track;
    logic                    w_holdLed;
    logic [NUM_DIGITS-1:0]   w_lit;
    logic [7*NUM_DIGITS-1:0] w_hex;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loadKey (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_keyN  (KEY_LOAD_N),
        .o_press (w_loadPress)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clrKey (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_keyN  (KEY_CLR_N),
        .o_press (w_clrPress)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= LIVE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Clear always returns to LIVE; otherwise a load press toggles LIVE/HOLD.
    always_comb begin
        w_stateNext = r_state;
        if (w_clrPress) begin
            w_stateNext = LIVE;
        end else if (w_loadPress) begin
            w_stateNext = (r_state == LIVE) ? HOLD : LIVE;
        end
    end

    // State-derived outputs: track input while LIVE, light the LED while HOLD.
    always_comb begin
        w_track   = 1'b0;
        w_holdLed = 1'b0;
        unique case (r_state)
            LIVE: w_track   = 1'b1;
            HOLD: w_holdLed = 1'b1;
        endcase
    end

    // Display register: cleared by a clear press, follows DATA_IN while LIVE, frozen in HOLD.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_disp <= '0;
        end else if (w_clrPress) begin
            r_disp <= '0;
        end else if (w_track) begin
            r_disp <= DATA_IN;
        end
    end

    // Count every accepted load press, wrapping silently.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pressCnt <= 8'd0;
        end else if (w_loadPress) begin
            r_pressCnt <= r_pressCnt + 8'd1;
        end
    end

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    // Light a digit only if it or any higher digit is non-zero; digit 0 is always lit.
    always_comb begin
        logic anySeen;
        anySeen = 1'b0;
        w_lit   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            anySeen  = anySeen | (r_disp[4*i +: 4] != 4'h0);
            w_lit[i] = anySeen | (i == 0);
        end
    end
`else
    // Every digit is always decoded.
    always_comb begin
        w_lit = '1;
    end
`endif

    // Per-digit segment decode from the display register.
    always_comb begin
        w_hex = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hex[7*i +: 7] = w_lit[i] ? SEG_LUT[r_disp[4*i +: 4]] : SEG_BLANK;
        end
    end

    assign HEX_OUT   = w_hex;
    assign HOLD_LED  = w_holdLed;
    assign PRESS_CNT = r_pressCnt;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with NUM_DIGITS=4, DEBOUNCE_CYCLES=4.
// Expected segment patterns are hand-written; blanked variants apply when
// HEX_DISPLAY_LEADING_ZERO_BLANK_EN is defined.
module tb_hex_display_ctrl;

    localparam int ND = 4;
    localparam int DC = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    localparam logic [27:0] H_12AF = {S1, S2, SA, SF};
    localparam logic [27:0] H_1234 = {S1, S2, S3, S4};
    localparam logic [27:0] H_7777 = {S7, S7, S7, S7};
    localparam logic [27:0] H_5555 = {S5, S5, S5, S5};
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [27:0] H_00C3 = {BL, BL, SC, S3};
    localparam logic [27:0] H_0ABC = {BL, SA, SB, SC};
    localparam logic [27:0] H_0000 = {BL, BL, BL, S0};
`else
    localparam logic [27:0] H_00C3 = {S0, S0, SC, S3};
    localparam logic [27:0] H_0ABC = {S0, SA, SB, SC};
    localparam logic [27:0] H_0000 = {S0, S0, S0, S0};
`endif

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic [15:0] DATA_IN;
    logic        KEY_LOAD_N;
    logic        KEY_CLR_N;
    logic [27:0] HEX_OUT;
    logic        HOLD_LED;
    logic [7:0]  PRESS_CNT;

    int total = 0;
    int bad   = 0;

    hex_display_ctrl #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DC)) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .DATA_IN    (DATA_IN),
        .KEY_LOAD_N (KEY_LOAD_N),
        .KEY_CLR_N  (KEY_CLR_N),
        .HEX_OUT    (HEX_OUT),
        .HOLD_LED   (HOLD_LED),
        .PRESS_CNT  (PRESS_CNT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic loadN, input logic clrN);
        DATA_IN    = data;
        KEY_LOAD_N = loadN;
        KEY_CLR_N  = clrN;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pressLoad();
        KEY_LOAD_N = 1'b0;
        cyc(7);
        KEY_LOAD_N = 1'b1;
        cyc(8);
    endtask

    initial begin
        applyStimulus(16'h0000, 1'b1, 1'b1);
        RESET_N = 1'b0;
        cyc(3);
        checkOutput("rst_hex", 32'(HEX_OUT), 32'(H_0000));
        checkOutput("rst_hold", 32'(HOLD_LED), 32'd0);
        checkOutput("rst_cnt", 32'(PRESS_CNT), 32'd0);
        RESET_N = 1'b1;
        cyc(8);

        applyStimulus(16'h12AF, 1'b1, 1'b1);
        cyc(1);
        checkOutput("live_12AF", 32'(HEX_OUT), 32'(H_12AF));
        checkOutput("live_hold", 32'(HOLD_LED), 32'd0);
        checkOutput("live_cnt", 32'(PRESS_CNT), 32'd0);

        applyStimulus(16'h00C3, 1'b0, 1'b1);
        cyc(6);
        checkOutput("load_hold_c6", 32'(HOLD_LED), 32'd0);
        cyc(1);
        checkOutput("load_hold_c7", 32'(HOLD_LED), 32'd1);
        checkOutput("load_hex", 32'(HEX_OUT), 32'(H_00C3));
        checkOutput("load_cnt", 32'(PRESS_CNT), 32'd1);
        applyStimulus(16'hFFFF, 1'b1, 1'b1);
        cyc(10);
        checkOutput("frozen_hex", 32'(HEX_OUT), 32'(H_00C3));
        checkOutput("release_cnt", 32'(PRESS_CNT), 32'd1);

        for (int k = 0; k < 5; k++) begin
            KEY_LOAD_N = 1'b0;
            cyc(2);
            KEY_LOAD_N = 1'b1;
            cyc(2);
        end
        cyc(8);
        checkOutput("bounce_hold", 32'(HOLD_LED), 32'd1);
        checkOutput("bounce_cnt", 32'(PRESS_CNT), 32'd1);
        checkOutput("bounce_hex", 32'(HEX_OUT), 32'(H_00C3));

        applyStimulus(16'h1234, 1'b0, 1'b0);
        cyc(7);
        checkOutput("both_hold", 32'(HOLD_LED), 32'd0);
        checkOutput("both_hex_clr", 32'(HEX_OUT), 32'(H_0000));
        checkOutput("both_cnt", 32'(PRESS_CNT), 32'd2);
        cyc(1);
        checkOutput("both_hex_track", 32'(HEX_OUT), 32'(H_1234));
        applyStimulus(16'h1234, 1'b1, 1'b1);
        cyc(8);

        applyStimulus(16'h0ABC, 1'b0, 1'b1);
        cyc(7);
        checkOutput("load2_hold", 32'(HOLD_LED), 32'd1);
        checkOutput("load2_hex", 32'(HEX_OUT), 32'(H_0ABC));
        checkOutput("load2_cnt", 32'(PRESS_CNT), 32'd3);
        applyStimulus(16'h7777, 1'b1, 1'b1);
        cyc(8);
        checkOutput("load2_frozen", 32'(HEX_OUT), 32'(H_0ABC));
        applyStimulus(16'h7777, 1'b0, 1'b1);
        cyc(7);
        checkOutput("unhold_led", 32'(HOLD_LED), 32'd0);
        checkOutput("unhold_hex_same", 32'(HEX_OUT), 32'(H_0ABC));
        checkOutput("unhold_cnt", 32'(PRESS_CNT), 32'd4);
        cyc(1);
        checkOutput("unhold_hex_track", 32'(HEX_OUT), 32'(H_7777));
        applyStimulus(16'h7777, 1'b1, 1'b1);
        cyc(8);

        applyStimulus(16'h5555, 1'b1, 1'b0);
        cyc(7);
        checkOutput("clr_hex", 32'(HEX_OUT), 32'(H_0000));
        checkOutput("clr_hold", 32'(HOLD_LED), 32'd0);
        checkOutput("clr_cnt", 32'(PRESS_CNT), 32'd4);
        cyc(1);
        checkOutput("clr_hex_track", 32'(HEX_OUT), 32'(H_5555));
        applyStimulus(16'h0000, 1'b1, 1'b1);
        cyc(8);
        checkOutput("zero_hex", 32'(HEX_OUT), 32'(H_0000));

        applyStimulus(16'h0000, 1'b0, 1'b1);
        cyc(3);
        RESET_N = 1'b0;
        cyc(1);
        checkOutput("midrst_cnt", 32'(PRESS_CNT), 32'd0);
        RESET_N = 1'b1;
        cyc(20);
        checkOutput("held_cnt", 32'(PRESS_CNT), 32'd0);
        checkOutput("held_hold", 32'(HOLD_LED), 32'd0);
        KEY_LOAD_N = 1'b1;
        cyc(10);
        pressLoad();
        checkOutput("repress_cnt", 32'(PRESS_CNT), 32'd1);
        checkOutput("repress_hold", 32'(HOLD_LED), 32'd1);

        repeat (255) pressLoad();
        checkOutput("wrap_cnt", 32'(PRESS_CNT), 32'd0);
        checkOutput("wrap_hold", 32'(HOLD_LED), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
